// File: rtl/conv_spectrum_unpack_pkg.sv
// Shared types and helpers for the spectrum tile deserializer.
//   complex_t         : one complex element, .i in the upper 32 bits, .r in the lower 32 bits
//   spec_tile_t       : 4 groups x 4 rows x 4 columns of complex_t
//   buf_state_e       : per-buffer assembly state
//   spec_elem_offset  : bit offset of element (row parity j, column k) inside a 512-bit beat
package conv_spectrum_unpack_pkg;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] r;
    } complex_t;

    typedef complex_t [0:3][0:3][0:3] spec_tile_t;

    localparam int SPEC_BEATS  = 8;
    localparam int SPEC_ELEM_W = 64;
    localparam int SPEC_LINE_W = 512;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    // A beat carries two rows; the odd row of the pair sits in the upper 256 bits.
    function automatic int spec_elem_offset(input int j, input int k);
        return 256 * (j & 1) + SPEC_ELEM_W * k;
    endfunction

endpackage

// File: rtl/conv_spectrum_unpack_tile_buf.sv
// One 4x4x4 complex tile register array with a beat-indexed write port.
// Ports:
//   clk   in   clock
//   we    in   write the beat on data into the rows selected by beat
//   beat  in   beat number 0..7 (group = beat>>1, row pair = beat&1)
//   data  in   512-bit beat
//   tile  out  current array contents (not reset)
module conv_spectrum_unpack_tile_buf
    import conv_spectrum_unpack_pkg::*;
(
    input  logic                   clk,
    input  logic                   we,
    input  logic [2:0]             beat,
    input  logic [SPEC_LINE_W-1:0] data,
    output spec_tile_t             tile
);

    spec_tile_t tile_q;
    spec_tile_t tile_d;
    logic [1:0] g_sel;

    assign g_sel = beat[2:1];

    always_comb begin
        tile_d = tile_q;
        if (we) begin
            for (int h = 0; h < 2; h++) begin
                for (int k = 0; k < 4; k++) begin
                    tile_d[g_sel][{beat[0], h[0]}][2'(k)] =
                        data[spec_elem_offset(h, k) +: SPEC_ELEM_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        tile_q <= tile_d;
    end

    assign tile = tile_q;

endmodule

// File: rtl/conv_spectrum_unpack.sv
// Deserializer: assembles 8 x 512-bit beats into one 4x4x4 complex tile,
// double-buffered, and hands finished tiles downstream as a next_out pulse
// followed one cycle later by out_valid with the tile on out.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   cacheline_in  beat data; in_valid/in_ready handshake; tile_sync marks beat 0
//   out_ready     downstream can take a tile (level)
//   next_out      one-cycle pulse announcing a tile on the next cycle
//   out_valid     high the cycle after next_out, out holds the tile
//   sync_err      one-cycle pulse on a framing error; err_count saturates
module conv_spectrum_unpack
    import conv_spectrum_unpack_pkg::*;
#(
    parameter int NUM_BUF   = 2,
    parameter int ISSUE_GAP = 2,
    parameter int ERR_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SPEC_LINE_W-1:0]    cacheline_in,
    input  logic                      in_valid,
    input  logic                      tile_sync,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic                      next_out,
    output logic                      out_valid,
    output complex_t [0:3][0:3][0:3]  out,
    output logic                      sync_err,
    output logic [ERR_W-1:0]          err_count
);

    buf_state_e        state_q [2];
    buf_state_e        state_d [2];
    logic              wr_buf_q, wr_buf_d;
    logic              rd_buf_q, rd_buf_d;
    logic [2:0]        beat_cnt_q, beat_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              next_out_q, next_out_d;
    logic              out_valid_q, out_valid_d;
    logic              sync_err_q, sync_err_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;

    logic              rx_open;
    logic              accept;
    logic              buf_we;
    logic [2:0]        wr_beat;
    logic              completing;
    logic              issue_buf;
    logic              issue_full;
    spec_tile_t        tile_w [2];

    assign rx_open    = !reset && (state_q[wr_buf_q] != BUF_FULL);
    assign accept     = in_valid && rx_open;
    assign buf_we     = accept && (tile_sync || (beat_cnt_q != 3'd0));
    assign wr_beat    = tile_sync ? 3'd0 : beat_cnt_q;
    assign completing = accept && !tile_sync && (beat_cnt_q == 3'd7);

    // While a tile is on out (out_valid), rd_buf still points at it, so the
    // next candidate is the other buffer. This keeps back-to-back issues at
    // ISSUE_GAP spacing without a second issue of the same buffer.
    assign issue_buf  = rd_buf_q ^ out_valid_q;
    // Forward a beat-7 acceptance so the tile can be announced the next cycle.
    assign issue_full = (state_q[issue_buf] == BUF_FULL) ||
                        (completing && (wr_buf_q == issue_buf));

    for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
        conv_spectrum_unpack_tile_buf u_tile_buf (
            .clk  (clk),
            .we   (buf_we && (wr_buf_q == 1'(b))),
            .beat (wr_beat),
            .data (cacheline_in),
            .tile (tile_w[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= '{default: BUF_EMPTY};
            wr_buf_q    <= 1'b0;
            rd_buf_q    <= 1'b0;
            beat_cnt_q  <= 3'd0;
            gap_cnt_q   <= 4'd0;
            next_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_buf_q    <= wr_buf_d;
            rd_buf_q    <= rd_buf_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            next_out_q  <= next_out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_buf_d    = wr_buf_q;
        rd_buf_d    = rd_buf_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sync_err_d  = 1'b0;
        err_count_d = err_count_q;

        if (accept) begin
            if (tile_sync) begin
                // A sync in the middle of a tile throws away the partial tile.
                sync_err_d         = (beat_cnt_q != 3'd0);
                state_d[wr_buf_q]  = BUF_FILLING;
                beat_cnt_d         = 3'd1;
            end else if (beat_cnt_q == 3'd0) begin
                sync_err_d = 1'b1;
            end else if (beat_cnt_q == 3'd7) begin
                state_d[wr_buf_q] = BUF_FULL;
                wr_buf_d          = ~wr_buf_q;
                beat_cnt_d        = 3'd0;
            end else begin
                beat_cnt_d = beat_cnt_q + 3'd1;
            end
        end

        next_out_d  = out_ready && (gap_cnt_q == 4'd0) && !next_out_q && issue_full;
        out_valid_d = next_out_q;

        // Reload one short: the registered pulse appears a cycle after the decision.
        if (next_out_d) begin
            gap_cnt_d = 4'(ISSUE_GAP - 1);
        end else if (gap_cnt_q != 4'd0) begin
            gap_cnt_d = gap_cnt_q - 4'd1;
        end

        if (out_valid_q) begin
            state_d[rd_buf_q] = BUF_EMPTY;
            rd_buf_d          = ~rd_buf_q;
        end

        if (sync_err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    always_comb begin
        in_ready  = rx_open;
        next_out  = next_out_q;
        out_valid = out_valid_q;
        sync_err  = sync_err_q;
        err_count = err_count_q;
        out       = tile_w[out_valid_q ? rd_buf_q : ~rd_buf_q];
    end

endmodule

// File: tb/tb_conv_spectrum_unpack.sv
module tb_conv_spectrum_unpack;
    import conv_spectrum_unpack_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [511:0]                cl = '0;
    logic                        ts = 1'b0;
    logic                        in_vld  [2];
    logic                        out_rdy [2];
    logic                        ir_w [2];
    logic                        nx_w [2];
    logic                        ov_w [2];
    logic                        se_w [2];
    logic [15:0]                 ec_w [2];
    complex_t [0:3][0:3][0:3]    dout [2];

    always #5 clk = ~clk;

    conv_spectrum_unpack #(.ISSUE_GAP(2)) u_dut0 (
        .clk(clk), .reset(reset), .cacheline_in(cl), .in_valid(in_vld[0]),
        .tile_sync(ts), .in_ready(ir_w[0]), .out_ready(out_rdy[0]),
        .next_out(nx_w[0]), .out_valid(ov_w[0]), .out(dout[0]),
        .sync_err(se_w[0]), .err_count(ec_w[0])
    );

    conv_spectrum_unpack #(.ISSUE_GAP(4)) u_dut1 (
        .clk(clk), .reset(reset), .cacheline_in(cl), .in_valid(in_vld[1]),
        .tile_sync(ts), .in_ready(ir_w[1]), .out_ready(out_rdy[1]),
        .next_out(nx_w[1]), .out_valid(ov_w[1]), .out(dout[1]),
        .sync_err(se_w[1]), .err_count(ec_w[1])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          sel = 0;
    int          cyc = 0;
    logic [63:0] tile_src [64];
    logic [63:0] cur [64];
    int          cur_cnt = 0;
    int          exp_err = 0;
    logic [63:0] exp_q [$];
    int          nx_cyc_q [$];
    int          n_next = 0;
    int          n_serr = 0;
    int          acc_cyc = 0;
    int          ov_cyc = 0;
    int          se_cyc = 0;
    logic        prev_nx = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // element (g,j,k) of a tile lives at index g*16 + j*4 + k
    function automatic logic [511:0] make_beat(input int b);
        logic [511:0] line;
        int g, h;
        g = b / 2;
        h = b % 2;
        line = '0;
        for (int jj = 0; jj < 2; jj++)
            for (int k = 0; k < 4; k++)
                line[256*jj + 64*k +: 64] = tile_src[g*16 + (2*h + jj)*4 + k];
        return line;
    endfunction

    task automatic model_store(input logic [511:0] d, input int b);
        int g, h;
        g = b / 2;
        h = b % 2;
        for (int jj = 0; jj < 2; jj++)
            for (int k = 0; k < 4; k++)
                cur[g*16 + (2*h + jj)*4 + k] = d[256*jj + 64*k +: 64];
    endtask

    task automatic model_beat(input logic [511:0] d, input logic s);
        if (s) begin
            if (cur_cnt != 0) exp_err++;
            model_store(d, 0);
            cur_cnt = 1;
        end else if (cur_cnt == 0) begin
            exp_err++;
        end else begin
            model_store(d, cur_cnt);
            cur_cnt++;
            if (cur_cnt == 8) begin
                for (int e = 0; e < 64; e++) exp_q.push_back(cur[e]);
                cur_cnt = 0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_nx = 1'b0;
        end else begin
            if (nx_w[sel]) begin
                nx_cyc_q.push_back(cyc);
                n_next++;
            end
            if (se_w[sel]) begin
                n_serr++;
                se_cyc = cyc;
            end
            if (nx_w[sel] || ov_w[sel] || prev_nx)
                chk("ov_after_next", 64'(ov_w[sel]), 64'(prev_nx));
            prev_nx = nx_w[sel];
            if (ov_w[sel]) begin
                ov_cyc = cyc;
                if (exp_q.size() < 64) begin
                    chk("tile_unexpected", 64'd1, 64'd0);
                end else begin
                    for (int g = 0; g < 4; g++)
                        for (int j = 0; j < 4; j++)
                            for (int k = 0; k < 4; k++)
                                chk($sformatf("elem_%0d%0d%0d", g, j, k),
                                    dout[sel][g][j][k], exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic [511:0] d, input logic s);
        int t;
        logic ok;
        cl = d;
        ts = s;
        in_vld[sel] = 1'b1;
        t = 0;
        ok = 1'b0;
        while (!ok && t < 300) begin
            @(negedge clk);
            if (ir_w[sel]) ok = 1'b1;
            else t++;
        end
        if (ok) begin
            acc_cyc = cyc;
            model_beat(d, s);
        end else begin
            chk("accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        in_vld[sel] = 1'b0;
        ts = 1'b0;
    endtask

    task automatic rand_tile();
        for (int e = 0; e < 64; e++) tile_src[e] = {$urandom, $urandom};
    endtask

    task automatic send_beats(input int first, input int last);
        for (int b = first; b <= last; b++) send_beat(make_beat(b), b == 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_vld[0] = 1'b0;
        in_vld[1] = 1'b0;
        ts = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 64'(ir_w[d]), 64'd0);
            chk("rst_next_out", 64'(nx_w[d]), 64'd0);
            chk("rst_out_valid", 64'(ov_w[d]), 64'd0);
            chk("rst_sync_err", 64'(se_w[d]), 64'd0);
            chk("rst_err_count", 64'(ec_w[d]), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        nx_cyc_q.delete();
        cur_cnt = 0;
        exp_err = 0;
        n_next = 0;
        n_serr = 0;
    endtask

    task automatic drain(input string tag, input int want_next);
        int t;
        t = 0;
        while (t < 200 && !(exp_q.size() == 0 && n_next >= want_next)) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_tiles"}, 64'(n_next), 64'(want_next));
        chk({tag, "_err_count"}, 64'(ec_w[sel]), 64'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic backpressure(input int gap);
        do_reset();
        out_rdy[sel] = 1'b0;
        rand_tile(); send_beats(0, 7);
        rand_tile(); send_beats(0, 7);
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 64'(ir_w[sel]), 64'd0);
        chk("bp_no_issue", 64'(n_next), 64'd0);
        @(posedge clk);
        #1;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                out_rdy[sel] = 1'b1;
            end
            begin
                rand_tile();
                send_beats(0, 7);
            end
        join
        drain("bp", 3);
        if (nx_cyc_q.size() >= 2)
            chk("bp_gap", 64'(nx_cyc_q[1] - nx_cyc_q[0]), 64'(gap));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cyc;
        in_vld[0] = 1'b0; in_vld[1] = 1'b0;
        out_rdy[0] = 1'b1; out_rdy[1] = 1'b1;

        // single tile with the documented pattern
        do_reset();
        @(negedge clk);
        chk("in_ready_after_reset", 64'(ir_w[0]), 64'd1);
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++) begin
                    logic [31:0] r;
                    r = 32'(256*g + 16*j + k);
                    tile_src[g*16 + j*4 + k] = {32'hFFFF0000 | r, r};
                end
        send_beats(0, 7);
        drain("single", 1);
        if (nx_cyc_q.size() >= 1)
            chk("lat_next_out", 64'(nx_cyc_q[0] - acc_cyc), 64'd1);
        chk("lat_out_valid", 64'(ov_cyc - acc_cyc), 64'd2);

        // backpressure with both gap settings
        sel = 0;
        backpressure(2);
        sel = 1;
        backpressure(4);
        sel = 0;
        out_rdy[1] = 1'b1;

        // sync arriving on beat 5 restarts the tile
        do_reset();
        out_rdy[0] = 1'b1;
        rand_tile(); send_beats(0, 4);
        rand_tile(); send_beats(0, 0);
        bad_cyc = acc_cyc;
        send_beats(1, 7);
        drain("missync", 1);
        chk("missync_serr_cnt", 64'(n_serr), 64'd1);
        chk("missync_serr_lat", 64'(se_cyc - bad_cyc), 64'd1);
        chk("missync_err_one", 64'(ec_w[0]), 64'd1);

        // beats with no sync while idle are dropped
        do_reset();
        send_beat({16{$urandom}}, 1'b0);
        send_beat({16{$urandom}}, 1'b0);
        rand_tile(); send_beats(0, 7);
        drain("nosync", 1);
        chk("nosync_err_two", 64'(ec_w[0]), 64'd2);

        // random input bubbles and downstream stalls
        do_reset();
        for (int t = 0; t < 4; t++) begin
            rand_tile();
            for (int b = 0; b < 8; b++) begin
                while ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                end
                out_rdy[0] = ($urandom_range(0, 3) != 0);
                send_beat(make_beat(b), b == 0);
            end
        end
        out_rdy[0] = 1'b1;
        drain("bubbles", 4);

        // reset with one tile full and a second half-filled
        do_reset();
        out_rdy[0] = 1'b0;
        rand_tile(); send_beats(0, 7);
        rand_tile(); send_beats(0, 3);
        do_reset();
        out_rdy[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_issue", 64'(n_next), 64'd0);
        chk("midrst_in_ready", 64'(ir_w[0]), 64'd1);
        chk("midrst_err_count", 64'(ec_w[0]), 64'd0);
        @(posedge clk);
        #1;
        rand_tile(); send_beats(0, 7);
        drain("midrst", 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
